// File: rtl/card_shoe_if.sv
// Handshake and card bus between the game controller (master) and the shoe dealer (slave).
interface card_shoe_if #(
  parameter int LFSR_W = 16
);
  logic              req;
  logic              reshuffle;
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              busy;
  logic              card_valid;
  logic [3:0]        card_rank;
  logic [3:0]        card_value;
  logic              ace_pres;
  logic [8:0]        cards_left;
  logic              shoe_empty;
  logic              empty_err;

  modport master (
    output req, reshuffle, seed_load, seed,
    input  busy, card_valid, card_rank, card_value, ace_pres, cards_left, shoe_empty, empty_err
  );

  modport slave (
    input  req, reshuffle, seed_load, seed,
    output busy, card_valid, card_rank, card_value, ace_pres, cards_left, shoe_empty, empty_err
  );
endinterface

// File: rtl/card_shoe_dealer.sv
// Deals blackjack ranks without replacement from a DECKS-deck shoe using a Galois LFSR,
// with per-rank counts and a bounded linear fallback scan so every request terminates.
module card_shoe_dealer #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int                DECKS     = 1,
  parameter int                MAX_TRIES = 32
) (
  input  logic         clk,
  input  logic         reset,
  card_shoe_if.slave   bus
);

  localparam int                TRY_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0]  LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [5:0]        FULL_CNT  = 6'(4 * DECKS);
  localparam logic [8:0]        FULL_SHOE = 9'(52 * DECKS);

  typedef enum logic [1:0] {IDLE, DRAW, SCAN} state_t;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [5:0]        count [1:13];
  logic [TRY_W-1:0]  tries;
  logic [3:0]        ptr;
  logic [8:0]        cards_left;

  logic [3:0] cand, sel;
  logic [5:0] sel_cnt;
  logic       sel_ok;
  logic       accept, restore, start, load_seed, err_hit, reject, go_scan;

  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Scan entry point is (c mod 13)+1 for a 4-bit candidate.
  function automatic logic [3:0] scan_start(input logic [3:0] c);
    return (c >= 4'd13) ? 4'(c - 4'd12) : 4'(c + 4'd1);
  endfunction

  assign cand = lfsr[3:0];
  assign sel  = (state == SCAN) ? ptr : cand;

  // Out-of-range candidates (0, 14, 15) read as an empty count and are rejected.
  always_comb begin
    sel_cnt = '0;
    for (int r = 1; r <= 13; r++)
      if (sel == 4'(r)) sel_cnt = count[r];
  end
  assign sel_ok = (sel_cnt != 6'd0);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    restore   = 1'b0;
    start     = 1'b0;
    load_seed = 1'b0;
    err_hit   = 1'b0;
    reject    = 1'b0;
    go_scan   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.reshuffle)      restore   = 1'b1;
        else if (bus.seed_load) load_seed = 1'b1;
        else if (bus.req) begin
          if (cards_left == 9'd0) err_hit = 1'b1;
          else begin
            start     = 1'b1;
            state_nxt = DRAW;
          end
        end
      end
      DRAW: begin
        if (bus.reshuffle) begin
          restore   = 1'b1;
          state_nxt = IDLE;
        end else if (sel_ok) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end else begin
          reject = 1'b1;
          if (tries == LAST_TRY) begin
            go_scan   = 1'b1;
            state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (bus.reshuffle) begin
          restore   = 1'b1;
          state_nxt = IDLE;
        end else if (sel_ok) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         lfsr <= SEED;
    else if (load_seed) lfsr <= (bus.seed == '0) ? SEED : bus.seed;
    else                lfsr <= lfsr_step(lfsr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tries <= '0;
      ptr   <= 4'd1;
    end else begin
      if (start)       tries <= '0;
      else if (reject) tries <= TRY_W'(tries + 1'b1);
      if (go_scan)                        ptr <= scan_start(cand);
      else if (state == SCAN && !sel_ok)  ptr <= (ptr == 4'd13) ? 4'd1 : 4'(ptr + 4'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r <= 13; r++) count[r] <= FULL_CNT;
      cards_left <= FULL_SHOE;
    end else if (restore) begin
      for (int r = 1; r <= 13; r++) count[r] <= FULL_CNT;
      cards_left <= FULL_SHOE;
    end else if (accept) begin
      for (int r = 1; r <= 13; r++)
        if (sel == 4'(r)) count[r] <= count[r] - 6'd1;
      cards_left <= cards_left - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.card_valid <= 1'b0;
      bus.empty_err  <= 1'b0;
      bus.card_rank  <= 4'd0;
      bus.card_value <= 4'd0;
      bus.ace_pres   <= 1'b0;
    end else begin
      bus.card_valid <= accept;
      bus.empty_err  <= err_hit;
      if (accept) begin
        bus.card_rank  <= sel;
        bus.card_value <= rank_value(sel);
        bus.ace_pres   <= (sel == 4'd1);
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.cards_left = cards_left;
  assign bus.shoe_empty = (cards_left == 9'd0);

endmodule
